// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the dual-issue fetch stage.
package fetch_unit_pkg;
  localparam int PC_W    = 8;
  localparam int INSTR_W = 32;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;

  localparam logic [PC_W-1:0]    RESET_PC_DEF = 8'h00;
  localparam logic [5:0]         HALT_OPC_DEF = 6'h3F;
  localparam logic [INSTR_W-1:0] NOP_INSTR    = '0;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  function automatic logic [5:0] opcode(input logic [INSTR_W-1:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: control in from decode/execute, imem read ports, IF/ID outputs.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic               stall;
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic [PC_W-1:0]    imem_addr1;
  logic [PC_W-1:0]    imem_addr2;
  logic [INSTR_W-1:0] imem_data1;
  logic [INSTR_W-1:0] imem_data2;
  logic [PC_W-1:0]    pc_out;
  logic [INSTR_W-1:0] instruction1;
  logic [INSTR_W-1:0] instruction2;
  logic               flush_out;
  logic               halted;

  modport master (
    input  stall, redirect, redirect_pc, imem_data1, imem_data2,
    output imem_addr1, imem_addr2, pc_out, instruction1, instruction2, flush_out, halted
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_data1, imem_data2,
    input  imem_addr1, imem_addr2, pc_out, instruction1, instruction2, flush_out, halted
  );
endinterface

// File: rtl/fetch_unit_pc_next_logic.sv
// Next-PC priority mux with wrap-around adders; purely combinational.
module fetch_unit_pc_next_logic
  import fetch_unit_pkg::*;
(
  input  fetch_state_e    state,
  input  logic [PC_W-1:0] pc,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            stall,
  input  logic            halt1,
  input  logic            halt2,
  output logic [PC_W-1:0] pc_inc1,
  output logic [PC_W-1:0] pc_d
);
  logic [PC_W-1:0] pc_inc2;

  // Adds truncate to PC_W bits, giving mod-2^PC_W wrap for free.
  assign pc_inc1 = pc + PC_W'(1);
  assign pc_inc2 = pc + PC_W'(2);

  always_comb begin
    pc_d = pc;
    unique case (state)
      ST_BOOT: if (redirect) pc_d = redirect_pc;
      ST_RUN: begin
        if (redirect)   pc_d = redirect_pc;
        else if (stall) pc_d = pc;
        else if (halt1) pc_d = pc;
        else if (halt2) pc_d = pc_inc1;
        else            pc_d = pc_inc2;
      end
      ST_HALT: if (redirect) pc_d = redirect_pc;
      default: pc_d = pc;
    endcase
  end
endmodule

// File: rtl/fetch_unit.sv
// Dual-issue fetch: owns PC and BOOT/RUN/HALT FSM, feeds the IF/ID register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [5:0]      HALT_OPC = HALT_OPC_DEF
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);
  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc1;
  logic            halted_q, halted_d;
  logic            halt1, halt2, issue;

  assign halt1 = (opcode(bus.imem_data1) == HALT_OPC);
  assign halt2 = (opcode(bus.imem_data2) == HALT_OPC);
  assign issue = (state_q == ST_RUN) && !bus.redirect;

  fetch_unit_pc_next_logic u_pc_next_logic (
    .state       (state_q),
    .pc          (pc_q),
    .redirect    (bus.redirect),
    .redirect_pc (bus.redirect_pc),
    .stall       (bus.stall),
    .halt1       (halt1),
    .halt2       (halt2),
    .pc_inc1     (pc_inc1),
    .pc_d        (pc_d)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  if (!bus.redirect && !bus.stall && (halt1 || halt2)) state_d = ST_HALT;
      ST_HALT: if (bus.redirect) state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
    halted_d = (state_d == ST_HALT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      state_q  <= ST_BOOT;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  assign bus.imem_addr1   = pc_q;
  assign bus.imem_addr2   = pc_inc1;
  assign bus.pc_out       = pc_q;
  assign bus.flush_out    = bus.redirect;
  assign bus.halted       = halted_q;
  // A slot-1 HALT kills the younger slot-2 instruction in the same pair.
  assign bus.instruction1 = issue ? bus.imem_data1 : NOP_INSTR;
  assign bus.instruction2 = (issue && !halt1) ? bus.imem_data2 : NOP_INSTR;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed scoreboard bench for fetch_unit: per-cycle expected outputs queued then compared.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  typedef struct {
    string       tag;
    logic [7:0]  pc;
    logic [7:0]  a2;
    logic [31:0] i1;
    logic [31:0] i2;
    logic        fl;
    logic        hl;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem [256];

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.imem_data1 = mem[bus.imem_addr1];
  assign bus.imem_data2 = mem[bus.imem_addr2];

  function automatic logic [31:0] m(input int n);
    logic [7:0] b;
    b = 8'(n);
    return {8'hA5, 16'h0000, b};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expected outputs, compare at negedge.
  task automatic cyc(input string tag, input bit st, input bit rd, input logic [7:0] rpc,
                     input bit rst, input logic [7:0] epc, input logic [31:0] e1,
                     input logic [31:0] e2, input bit ef, input bit eh);
    exp_t e;
    exp_t o;
    e.tag = tag; e.pc = epc; e.a2 = epc + 8'd1;
    e.i1 = e1; e.i2 = e2; e.fl = ef; e.hl = eh;
    bus.stall = st; bus.redirect = rd; bus.redirect_pc = rpc; reset = rst;
    exp_q.push_back(e);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      chk({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      o = exp_q.pop_front();
      chk({o.tag, "_pc"},    {24'h0, bus.pc_out},     {24'h0, o.pc});
      chk({o.tag, "_addr1"}, {24'h0, bus.imem_addr1}, {24'h0, o.pc});
      chk({o.tag, "_addr2"}, {24'h0, bus.imem_addr2}, {24'h0, o.a2});
      chk({o.tag, "_i1"},    bus.instruction1,        o.i1);
      chk({o.tag, "_i2"},    bus.instruction2,        o.i2);
      chk({o.tag, "_flush"}, {31'h0, bus.flush_out},  {31'h0, o.fl});
      chk({o.tag, "_halt"},  {31'h0, bus.halted},     {31'h0, o.hl});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = m(i);
    bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 8'h00;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // boot then free-running advance
    cyc("boot",   0, 0, 8'h00, 0, 8'h00, 32'h0, 32'h0, 0, 0);
    cyc("run0",   0, 0, 8'h00, 0, 8'h00, m(0),  m(1),  0, 0);
    cyc("run2",   0, 0, 8'h00, 0, 8'h02, m(2),  m(3),  0, 0);
    // stall holds pc at 04
    cyc("stall1", 1, 0, 8'h00, 0, 8'h04, m(4),  m(5),  0, 0);
    cyc("stall2", 1, 0, 8'h00, 0, 8'h04, m(4),  m(5),  0, 0);
    cyc("rel",    0, 0, 8'h00, 0, 8'h04, m(4),  m(5),  0, 0);
    cyc("adv06",  0, 0, 8'h00, 0, 8'h06, m(6),  m(7),  0, 0);
    for (int p = 8; p < 16; p += 2)
      cyc("adv", 0, 0, 8'h00, 0, 8'(p), m(p), m(p + 1), 0, 0);
    // redirect beats stall
    cyc("rdst",   1, 1, 8'h31, 0, 8'h10, 32'h0, 32'h0, 1, 0);
    cyc("odd31",  0, 0, 8'h00, 0, 8'h31, m(8'h31), m(8'h32), 0, 0);
    // wrap-around
    cyc("rdFF",   0, 1, 8'hFF, 0, 8'h33, 32'h0, 32'h0, 1, 0);
    cyc("pcFF",   0, 0, 8'h00, 0, 8'hFF, m(8'hFF), m(8'h00), 0, 0);
    cyc("wrap01", 0, 0, 8'h00, 0, 8'h01, m(8'h01), m(8'h02), 0, 0);
    // HALT in slot 1
    mem[8] = 32'hFC00_0008;
    cyc("rd08a",  0, 1, 8'h08, 0, 8'h03, 32'h0, 32'h0, 1, 0);
    cyc("h1det",  0, 0, 8'h00, 0, 8'h08, 32'hFC00_0008, 32'h0, 0, 0);
    cyc("h1frz",  0, 0, 8'h00, 0, 8'h08, 32'h0, 32'h0, 0, 1);
    cyc("h1frz2", 1, 0, 8'h00, 0, 8'h08, 32'h0, 32'h0, 0, 1);
    cyc("hexit",  0, 1, 8'h20, 0, 8'h08, 32'h0, 32'h0, 1, 1);
    cyc("pc20",   0, 0, 8'h00, 0, 8'h20, m(8'h20), m(8'h21), 0, 0);
    // HALT in slot 2
    mem[8] = m(8);
    mem[9] = 32'hFC00_0009;
    cyc("rd08b",  0, 1, 8'h08, 0, 8'h22, 32'h0, 32'h0, 1, 0);
    cyc("h2det",  0, 0, 8'h00, 0, 8'h08, m(8), 32'hFC00_0009, 0, 0);
    cyc("h2frz",  0, 0, 8'h00, 0, 8'h09, 32'h0, 32'h0, 0, 1);
    cyc("hexit2", 0, 1, 8'h3E, 0, 8'h09, 32'h0, 32'h0, 1, 1);
    cyc("pc3E",   0, 0, 8'h00, 0, 8'h3E, m(8'h3E), m(8'h3F), 0, 0);
    // reset mid-run beats a concurrent redirect
    cyc("rst40",  0, 1, 8'h77, 1, 8'h40, 32'h0, 32'h0, 1, 0);
    cyc("rboot",  0, 0, 8'h00, 0, 8'h00, 32'h0, 32'h0, 0, 0);
    cyc("rrun",   0, 0, 8'h00, 0, 8'h00, m(0), m(1), 0, 0);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
